// File: rtl/dcache_pkg.sv
// Shared dcache write-path types and constants.
// Imported by the dcache, the write-back buffer and the AXI bridge.
package dcache_pkg;

  localparam logic [2:0] WR_TYPE_WORD = 3'b010;
  localparam logic [2:0] WR_TYPE_LINE = 3'b100;
  localparam int LINE_OFFSET_W = 4;

  typedef struct packed {
    logic [2:0]   wr_type;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } wb_entry_t;

endpackage

// File: rtl/dcache_wb_buffer.sv
// FIFO write-back buffer between dcache and AXI bridge.
// Queues dirty lines and word stores; flags refill reads hitting them.
module dcache_wb_buffer
  import dcache_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         in_wr_req,
  input  logic [2:0]   in_wr_type,
  input  logic [31:0]  in_wr_addr,
  input  logic [3:0]   in_wr_wstrb,
  input  logic [127:0] in_wr_data,
  output logic         in_wr_rdy,
  output logic         out_wr_req,
  output logic [2:0]   out_wr_type,
  output logic [31:0]  out_wr_addr,
  output logic [3:0]   out_wr_wstrb,
  output logic [127:0] out_wr_data,
  input  logic         out_wr_rdy,
  input  logic [31:0]  chk_addr,
  output logic         chk_hit,
  output logic         wb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] hit_vec;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;
  wb_entry_t        head;

  assign in_wr_rdy  = (cnt != CW'(DEPTH));
  assign out_wr_req = (cnt != '0);
  assign wb_empty   = (cnt == '0);

  assign push = in_wr_req & in_wr_rdy;
  assign pop  = out_wr_req & out_wr_rdy;

  assign head         = mem[rd_ptr];
  assign out_wr_type  = head.wr_type;
  assign out_wr_addr  = head.addr;
  assign out_wr_wstrb = head.wstrb;
  assign out_wr_data  = head.data;

  // payload capture; contents are don't-care until marked valid
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= '{wr_type: in_wr_type,
                       addr:    in_wr_addr,
                       wstrb:   in_wr_wstrb,
                       data:    in_wr_data};
    end
  end

  // valid bits and pointers; wr_ptr==rd_ptr only when empty or full
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PW'(1);
      end
    end
  end

  // occupancy count; simultaneous push and pop leaves it unchanged
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else begin
      unique case (1'b1)
        push && !pop: cnt <= cnt + CW'(1);
        pop && !push: cnt <= cnt - CW'(1);
        default:      cnt <= cnt;
      endcase
    end
  end

  // line-granular hazard compare against every queued entry
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign hit_vec[g] = vld[g] &
      (mem[g].addr[31:LINE_OFFSET_W] == chk_addr[31:LINE_OFFSET_W]);
  end

  assign chk_hit = |hit_vec;

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Bench for dcache_wb_buffer: directed steps then random traffic.
// Outputs are compared against a queue-based model each cycle.
module tb_dcache_wb_buffer;
  import dcache_pkg::*;

  localparam int DEPTH = 2;

  logic         aclk;
  logic         aresetn;
  logic         in_wr_req;
  logic [2:0]   in_wr_type;
  logic [31:0]  in_wr_addr;
  logic [3:0]   in_wr_wstrb;
  logic [127:0] in_wr_data;
  logic         in_wr_rdy;
  logic         out_wr_req;
  logic [2:0]   out_wr_type;
  logic [31:0]  out_wr_addr;
  logic [3:0]   out_wr_wstrb;
  logic [127:0] out_wr_data;
  logic         out_wr_rdy;
  logic [31:0]  chk_addr;
  logic         chk_hit;
  logic         wb_empty;

  int n_cmp;
  int n_fail;

  wb_entry_t q[$];

  dcache_wb_buffer #(.DEPTH(DEPTH)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .in_wr_req    (in_wr_req),
    .in_wr_type   (in_wr_type),
    .in_wr_addr   (in_wr_addr),
    .in_wr_wstrb  (in_wr_wstrb),
    .in_wr_data   (in_wr_data),
    .in_wr_rdy    (in_wr_rdy),
    .out_wr_req   (out_wr_req),
    .out_wr_type  (out_wr_type),
    .out_wr_addr  (out_wr_addr),
    .out_wr_wstrb (out_wr_wstrb),
    .out_wr_data  (out_wr_data),
    .out_wr_rdy   (out_wr_rdy),
    .chk_addr     (chk_addr),
    .chk_hit      (chk_hit),
    .wb_empty     (wb_empty)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [127:0] o,
                     input logic [127:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // model hazard: any queued entry in the same 16-byte line
  function automatic logic model_hit(input logic [31:0] ca);
    logic h;
    h = 1'b0;
    foreach (q[i])
      if (q[i].addr[31:4] == ca[31:4]) h = 1'b1;
    return h;
  endfunction

  // one cycle: drive at negedge, check before posedge, update model
  task automatic cyc(input logic rq, input logic [2:0] ty,
                     input logic [31:0] ad, input logic [3:0] st,
                     input logic [127:0] dt, input logic ordy,
                     input logic [31:0] ca);
    bit do_push;
    bit do_pop;
    in_wr_req   = rq;
    in_wr_type  = ty;
    in_wr_addr  = ad;
    in_wr_wstrb = st;
    in_wr_data  = dt;
    out_wr_rdy  = ordy;
    chk_addr    = ca;
    #1;
    chk("in_wr_rdy", 128'(in_wr_rdy), 128'(q.size() != DEPTH));
    chk("out_wr_req", 128'(out_wr_req), 128'(q.size() != 0));
    chk("wb_empty", 128'(wb_empty), 128'(q.size() == 0));
    chk("chk_hit", 128'(chk_hit), 128'(model_hit(ca)));
    if (q.size() != 0) begin
      chk("out_type", 128'(out_wr_type), 128'(q[0].wr_type));
      chk("out_addr", 128'(out_wr_addr), 128'(q[0].addr));
      chk("out_wstrb", 128'(out_wr_wstrb), 128'(q[0].wstrb));
      chk("out_data", out_wr_data, q[0].data);
    end
    do_push = rq && (q.size() < DEPTH);
    do_pop  = ordy && (q.size() > 0);
    @(posedge aclk);
    if (do_pop) void'(q.pop_front());
    if (do_push)
      q.push_back('{wr_type: ty, addr: ad, wstrb: st, data: dt});
    @(negedge aclk);
  endtask

  task automatic idle(input logic ordy, input logic [31:0] ca);
    cyc(1'b0, 3'b000, 32'h0, 4'h0, 128'h0, ordy, ca);
  endtask

  task automatic line(input logic [31:0] ad, input logic [127:0] dt,
                      input logic ordy, input logic [31:0] ca);
    cyc(1'b1, WR_TYPE_LINE, ad, 4'hF, dt, ordy, ca);
  endtask

  localparam logic [127:0] D0 =
    128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    aresetn     = 1'b0;
    in_wr_req   = 1'b0;
    in_wr_type  = 3'b000;
    in_wr_addr  = 32'h0;
    in_wr_wstrb = 4'h0;
    in_wr_data  = 128'h0;
    out_wr_rdy  = 1'b0;
    chk_addr    = 32'h0;
    #12;
    chk("rst_in_wr_rdy", 128'(in_wr_rdy), 128'd1);
    chk("rst_out_wr_req", 128'(out_wr_req), 128'd0);
    chk("rst_wb_empty", 128'(wb_empty), 128'd1);
    chk("rst_chk_hit", 128'(chk_hit), 128'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    // single push, popped on first visible cycle
    line(32'h1C00_0040, D0, 1'b1, 32'h1C00_0040);
    idle(1'b1, 32'h1C00_0040);
    idle(1'b1, 32'h1C00_0040);
    chk("single_drained", 128'(wb_empty), 128'd1);

    // fill under backpressure, third request dropped
    line(32'h0000_0100, 128'h100, 1'b0, 32'h0);
    line(32'h0000_0200, 128'h200, 1'b0, 32'h0);
    line(32'h0000_0300, 128'h300, 1'b0, 32'h300);
    chk("full_rdy_low", 128'(in_wr_rdy), 128'd0);
    idle(1'b0, 32'h0000_0100);
    chk("head_0x100", 128'(out_wr_addr), 128'h100);
    idle(1'b1, 32'h0);
    chk("head_0x200", 128'(out_wr_addr), 128'h200);
    idle(1'b1, 32'h0);
    idle(1'b1, 32'h0);

    // push and pop together with one entry held; pointers wrap
    line(32'h0000_1000, 128'h1000, 1'b0, 32'h0);
    for (int i = 1; i <= 8; i++)
      line(32'h0000_1000 + 32'(i) * 32'h10, 128'(i), 1'b1,
           32'h0000_1000 + 32'(i) * 32'h10);
    chk("pp_one_left", 128'(out_wr_addr), 128'h1080);
    idle(1'b1, 32'h0);
    idle(1'b1, 32'h0);

    // hazard compare at line granularity across the pop cycle
    line(32'h1C00_0040, D0, 1'b0, 32'h1C00_004C);
    idle(1'b0, 32'h1C00_004C);
    idle(1'b0, 32'h1C00_0050);
    idle(1'b1, 32'h1C00_004C);
    idle(1'b1, 32'h1C00_004C);

    // uncached word store
    cyc(1'b1, WR_TYPE_WORD, 32'hBFAF_8000, 4'b0011,
        128'h0000_BEEF, 1'b0, 32'hBFAF_8004);
    idle(1'b0, 32'hBFAF_8000);
    chk("word_wstrb", 128'(out_wr_wstrb), 128'b0011);
    chk("word_data", 128'(out_wr_data[31:0]), 128'h0000_BEEF);
    idle(1'b1, 32'h0);
    idle(1'b1, 32'h0);

    // asynchronous reset with two entries queued
    line(32'h0000_0100, 128'hA, 1'b0, 32'h0);
    line(32'h0000_0200, 128'hB, 1'b0, 32'h0);
    #2;
    chk_addr = 32'h0000_0100;
    aresetn  = 1'b0;
    #1;
    chk("arst_out_wr_req", 128'(out_wr_req), 128'd0);
    chk("arst_in_wr_rdy", 128'(in_wr_rdy), 128'd1);
    chk("arst_wb_empty", 128'(wb_empty), 128'd1);
    chk("arst_chk_hit", 128'(chk_hit), 128'd0);
    q.delete();
    @(negedge aclk);
    aresetn = 1'b1;
    idle(1'b1, 32'h0000_0100);

    // random traffic over a few lines so hazards and full occur
    for (int i = 0; i < 400; i++) begin
      logic [2:0]   ty;
      logic [31:0]  ad;
      logic [31:0]  ca;
      logic [127:0] dt;
      ty = ($urandom_range(0, 1) == 0) ? WR_TYPE_WORD : WR_TYPE_LINE;
      ad = 32'h1C00_0000 | (32'($urandom_range(0, 7)) << 4);
      if (ty == WR_TYPE_WORD) ad = ad | (32'($urandom_range(0, 3)) << 2);
      ca = 32'h1C00_0000 | 32'($urandom_range(0, 127));
      dt = {$urandom, $urandom, $urandom, $urandom};
      cyc(1'($urandom_range(0, 1)), ty, ad, 4'($urandom), dt,
          ($urandom_range(0, 2) != 0), ca);
    end
    for (int i = 0; i < 4; i++) idle(1'b1, 32'h0);
    chk("final_empty", 128'(wb_empty), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
